// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: slot layout, CDB packet and branch encodings.
package alu_rs_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned BR_W      = 2;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BNE  = 2'b01;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b10;
    localparam logic [BR_W-1:0] BR_BLT  = 2'b11;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] dest_ROB_entry;
        logic [XLEN-1:0]      result;
    } CDB_packet_t;

    typedef struct packed {
        logic                 busy;
        logic                 alu_op;
        logic [BR_W-1:0]      br_type;
        logic [ROB_TAG_W-1:0] rob;
        logic [XLEN-1:0]      v1;
        logic [ROB_TAG_W-1:0] t1;
        logic                 r1;
        logic [XLEN-1:0]      v2;
        logic [ROB_TAG_W-1:0] t2;
        logic                 r2;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins, returned one-hot.
module prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = req & (~req + N'(1));
    assign any   = |req;

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the add/sub/branch unit: holds ops until operands arrive, snoops CDB, issues one per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned ROB_W       = ROB_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic               disp_alu_op,
    input  logic [BR_W-1:0]    disp_br_type,
    input  logic [ROB_W-1:0]   disp_rob,
    input  logic [XLEN-1:0]    disp_v1,
    input  logic [ROB_W-1:0]   disp_t1,
    input  logic               disp_r1,
    input  logic [XLEN-1:0]    disp_v2,
    input  logic [ROB_W-1:0]   disp_t2,
    input  logic               disp_r2,
    input  logic               cdb_valid,
    input  CDB_packet_t        cdb,
    output logic               issue_valid,
    input  logic               fu_ready,
    output logic [XLEN-1:0]    issue_rs1,
    output logic [XLEN-1:0]    issue_rs2,
    output logic               issue_alu_op,
    output logic [BR_W-1:0]    issue_br_type,
    output logic [ROB_W-1:0]   issue_rob
);

    rs_entry_t ents     [NUM_ENTRIES];
    rs_entry_t ents_nxt [NUM_ENTRIES];
    rs_entry_t disp_entry;

    logic [NUM_ENTRIES-1:0] free_req;
    logic [NUM_ENTRIES-1:0] free_grant;
    logic [NUM_ENTRIES-1:0] ready_req;
    logic [NUM_ENTRIES-1:0] issue_grant;
    logic                   do_issue;
    logic                   do_disp;

    always_comb begin
        free_req  = '0;
        ready_req = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_req[i]  = ~ents[i].busy;
            ready_req[i] = ents[i].busy & ents[i].r1 & ents[i].r2;
        end
    end

    prio_enc #(.N(NUM_ENTRIES)) u_free_sel (
        .req   (free_req),
        .grant (free_grant),
        .any   (disp_ready)
    );

    prio_enc #(.N(NUM_ENTRIES)) u_ready_sel (
        .req   (ready_req),
        .grant (issue_grant),
        .any   (issue_valid)
    );

    assign do_issue = issue_valid & fu_ready;
    assign do_disp  = disp_valid & disp_ready;

    // AND-OR mux so the issue fields read zero when nothing is ready.
    always_comb begin
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_alu_op  = 1'b0;
        issue_br_type = '0;
        issue_rob     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_grant[i]) begin
                issue_rs1     = ents[i].v1;
                issue_rs2     = ents[i].v2;
                issue_alu_op  = ents[i].alu_op;
                issue_br_type = ents[i].br_type;
                issue_rob     = ents[i].rob;
            end
        end
    end

    // Incoming op, with same-cycle CDB bypass on each pending source.
    always_comb begin
        disp_entry         = '0;
        disp_entry.busy    = 1'b1;
        disp_entry.alu_op  = disp_alu_op;
        disp_entry.br_type = disp_br_type;
        disp_entry.rob     = disp_rob;
        disp_entry.v1      = disp_v1;
        disp_entry.t1      = disp_t1;
        disp_entry.r1      = disp_r1;
        disp_entry.v2      = disp_v2;
        disp_entry.t2      = disp_t2;
        disp_entry.r2      = disp_r2;
        if (cdb_valid && !disp_r1 && (disp_t1 == cdb.dest_ROB_entry)) begin
            disp_entry.v1 = cdb.result;
            disp_entry.r1 = 1'b1;
        end
        if (cdb_valid && !disp_r2 && (disp_t2 == cdb.dest_ROB_entry)) begin
            disp_entry.v2 = cdb.result;
            disp_entry.r2 = 1'b1;
        end
    end

    // Issue and dispatch grants are disjoint (busy vs free), so their writes never collide.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ents_nxt[i] = ents[i];
            if (ents[i].busy && cdb_valid) begin
                if (!ents[i].r1 && (ents[i].t1 == cdb.dest_ROB_entry)) begin
                    ents_nxt[i].v1 = cdb.result;
                    ents_nxt[i].r1 = 1'b1;
                end
                if (!ents[i].r2 && (ents[i].t2 == cdb.dest_ROB_entry)) begin
                    ents_nxt[i].v2 = cdb.result;
                    ents_nxt[i].r2 = 1'b1;
                end
            end
            if (do_issue && issue_grant[i]) begin
                ents_nxt[i].busy = 1'b0;
            end
            if (do_disp && free_grant[i]) begin
                ents_nxt[i] = disp_entry;
            end
            if (flush) begin
                ents_nxt[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (reset) begin
                ents[i] <= '0;
            end else begin
                ents[i] <= ents_nxt[i];
            end
        end
    end

endmodule
